pdw_rx: RTL and testbench
=========================

PDW_RX -- requirements
Module: pdw_rx

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 16: width of one snapshot sample and of the output word.
REQ-002 Parameter NUM_TAPS, default 10: number of samples per snapshot.
REQ-003 Parameter ABS_TIME_WIDTH, default 32: width of the snapshot timestamp.
REQ-004 Port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port pdw_data, input, 1: serial snapshot bit, sampled while pdw_frame=1.
REQ-007 Port pdw_frame, input, 1: frame-active qualifier.
REQ-008 Port word_o, output, SAMPLE_WIDTH: deserialized output word.
REQ-009 Port word_valid_o, output, 1: word_o holds a valid word.
REQ-010 Port word_ready_i, input, 1: downstream accepts word_o.
REQ-011 Port word_last_o, output, 1: the current word is the final word of its snapshot.
REQ-012 Port frame_err_o, output, 1: one-cycle pulse when a frame has the wrong bit count.
REQ-013 Port overrun_o, output, 1: one-cycle pulse when a good frame is dropped because the output buffer is occupied.
REQ-014 Port busy_o, output, 1: high while receiving, checking or draining.

Function
REQ-015 Payload length P shall be SAMPLE_WIDTH*NUM_TAPS+ABS_TIME_WIDTH bits (192 at the defaults); the frame length F shall be P, or P+16 when CRC is enabled.
REQ-016 Wire order shall be MSB first: the first bit is snapshot bit P-1, samples occupy the high bits, and the timestamp occupies the low ABS_TIME_WIDTH bits.
REQ-017 The receive FSM shall have the states IDLE, SHIFT and CHECK.
REQ-018 In IDLE, a cycle with pdw_frame=1 shall shift in pdw_data, set the bit count to 1 and move to SHIFT.
REQ-019 In SHIFT, each cycle with pdw_frame=1 shall shift one bit and increment the bit count, saturating at F+1; the first cycle with pdw_frame=0 shall move to CHECK.
REQ-020 A frame shall be good when the bit count equals F and, with CRC enabled, the CRC check passes.
REQ-021 In CHECK, lasting one cycle, a good frame shall be copied to the output holding register if that register is empty; a good frame with the register full shall pulse overrun_o and be discarded; a bad frame shall pulse frame_err_o and be discarded.
REQ-022 CHECK shall always return to IDLE, and a frame starting in the CHECK cycle shall be ignored, so the sender must leave at least 2 low cycles between frames.
REQ-023 Drain: the holding register shall emit P/SAMPLE_WIDTH words (12 at the defaults), highest word first, with word_last_o set on the final word.
REQ-024 Drain handshake: a word transfers when word_valid_o and word_ready_i are both 1; word_o and word_last_o shall stay stable while valid is high and ready is low.
REQ-025 The first word shall be valid on the cycle after the CHECK copy, with no bubbles between words while ready is held high.
REQ-026 The holding register shall become empty on the cycle after the last-word transfer; a CHECK copy in that same cycle shall be accepted, not flagged as overrun.
REQ-027 Receiving and draining shall proceed concurrently.
REQ-028 busy_o shall be high when the FSM is not in IDLE or the holding register is occupied.

Reset
REQ-029 On rst_n=0, asynchronously: FSM to IDLE, bit count to 0, holding register empty, word_valid_o=0, word_last_o=0, frame_err_o=0, overrun_o=0, busy_o=0, word_o=0.
REQ-030 Reset mid-frame or mid-drain shall discard all partial data, and no error pulse shall follow reset release.
REQ-031 After reset release, a frame already in progress (pdw_frame=1) shall be counted from its current bit and will therefore fail the length check.

Configuration
REQ-032 Macro PDW_RX_CRC_EN defined: the frame shall carry a trailing CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB first, computed over the P payload bits).
REQ-033 With PDW_RX_CRC_EN defined: F=P+16, a mismatch shall pulse the added output crc_err_o and the frame shall be discarded, and the CRC shall never be emitted on word_o.
REQ-034 Macro PDW_RX_CRC_EN undefined: F=P, and there shall be no crc_err_o port and no CRC logic.

Structure
REQ-035 The shared package pdw_pkg shall hold the FSM state enum, the CRC polynomial and init constants, and the P/F/word-count localparam functions, so they are reused by the transmitter.
REQ-036 The CRC shall be one sub-module, crc16_serial (1 bit per cycle, clear, enable), instantiated only under PDW_RX_CRC_EN.

Verification
REQ-037 A 192-bit frame with samples 0x0001..0x000A (sample index 9 first) and time 0xDEADBEEF, ready=1 -> 12 consecutive words 0x000A..0x0001, 0xDEAD, 0xBEEF, with last on 0xBEEF.
REQ-038 A 191-bit frame and a 193-bit frame -> one frame_err_o pulse each, and no words.
REQ-039 ready=0 during the drain, then a second good frame arrives -> one overrun_o pulse, and the first snapshot drains intact after ready=1.
REQ-040 ready toggling 1010... -> words are stable while stalled, and the sequence is identical to REQ-037.
REQ-041 rst_n asserted at bit 100 of a frame and in the middle of a drain -> all outputs are 0 immediately, and the next good frame is received correctly.
REQ-042 With PDW_RX_CRC_EN, one payload bit flipped -> crc_err_o pulses and no words; with the correct CRC -> output matches REQ-037.

Source files
------------

// File: rtl/pdw_pkg.sv
// Shared definitions for the PDW snapshot link: receive FSM states, CRC-16-CCITT
// constants and the payload/frame/word sizing functions used by receiver and transmitter.
package pdw_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StCheck
   } pdw_state_e;

   localparam logic [15:0] CRC_POLY = 16'h1021;
   localparam logic [15:0] CRC_INIT = 16'hFFFF;
   localparam int unsigned CRC_BITS = 16;

   function automatic int unsigned pdw_payload_bits(input int unsigned sample_width,
                                                    input int unsigned num_taps,
                                                    input int unsigned abs_time_width);
      return sample_width * num_taps + abs_time_width;
   endfunction

   function automatic int unsigned pdw_frame_bits(input int unsigned payload_bits,
                                                  input bit          crc_en);
      return crc_en ? payload_bits + CRC_BITS : payload_bits;
   endfunction

   function automatic int unsigned pdw_num_words(input int unsigned payload_bits,
                                                 input int unsigned sample_width);
      return payload_bits / sample_width;
   endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16-CCITT, MSB first. A clear in the same cycle as an enable folds the
// incoming bit into the init value, so the first frame bit is never lost.
module crc16_serial
   import pdw_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q;
   logic [15:0] base;
   logic [15:0] crc_d;

   always_comb begin
      base  = clr ? CRC_INIT : crc_q;
      crc_d = base;
      if (en) begin
         crc_d = {base[14:0], 1'b0} ^ ((base[15] ^ din) ? CRC_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= CRC_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/pdw_rx.sv
// Serial PDW snapshot receiver: shifts a framed bit stream, length/CRC checks it and drains
// the payload as ready/valid words. Optional trailing CRC-16 check under PDW_RX_CRC_EN.
module pdw_rx
   import pdw_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH   = 16,
   parameter int unsigned NUM_TAPS       = 10,
   parameter int unsigned ABS_TIME_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    pdw_data,
   input  logic                    pdw_frame,
   output logic [SAMPLE_WIDTH-1:0] word_o,
   output logic                    word_valid_o,
   input  logic                    word_ready_i,
   output logic                    word_last_o,
   output logic                    frame_err_o,
   output logic                    overrun_o,
`ifdef PDW_RX_CRC_EN
   output logic                    crc_err_o,
`endif
   output logic                    busy_o
);

`ifdef PDW_RX_CRC_EN
   localparam bit CrcEn = 1'b1;
`else
   localparam bit CrcEn = 1'b0;
`endif

   localparam int unsigned P   = pdw_payload_bits(SAMPLE_WIDTH, NUM_TAPS, ABS_TIME_WIDTH);
   localparam int unsigned F   = pdw_frame_bits(P, CrcEn);
   localparam int unsigned NW  = pdw_num_words(P, SAMPLE_WIDTH);
   localparam int unsigned CW  = $clog2(F + 2);
   localparam int unsigned NWW = $clog2(NW + 1);

   pdw_state_e     state_q;
   logic [CW-1:0]  cnt_q;
   logic [F-1:0]   sr_q;
   logic [P-1:0]   hold_q;
   logic           full_q;
   logic [NWW-1:0] left_q;
   logic           frame_err_q;
   logic           overrun_q;

   logic xfer;
   logic is_last;
   logic hold_free;
   logic len_ok;
   logic crc_ok;

   assign xfer    = full_q & word_ready_i;
   assign is_last = (left_q == NWW'(1));
   // The last-word transfer frees the register for a copy in the very same cycle.
   assign hold_free = !full_q || (xfer && is_last);
   assign len_ok    = (cnt_q == CW'(F));

`ifdef PDW_RX_CRC_EN
   logic [15:0] crc_calc;
   logic        crc_en;
   logic        crc_err_q;

   // Only the first P bits feed the CRC; the trailing 16 bits are the received checksum.
   assign crc_en = pdw_frame &&
                   ((state_q == StIdle) || ((state_q == StShift) && (cnt_q < CW'(P))));

   crc16_serial u_crc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == StIdle),
      .en    (crc_en),
      .din   (pdw_data),
      .crc   (crc_calc)
   );

   assign crc_ok    = (crc_calc == sr_q[CRC_BITS-1:0]);
   assign crc_err_o = crc_err_q;
`else
   assign crc_ok = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         sr_q        <= '0;
         hold_q      <= '0;
         full_q      <= 1'b0;
         left_q      <= '0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef PDW_RX_CRC_EN
         crc_err_q   <= 1'b0;
`endif
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
`ifdef PDW_RX_CRC_EN
         crc_err_q   <= 1'b0;
`endif

         if (xfer) begin
            hold_q <= hold_q << SAMPLE_WIDTH;
            left_q <= left_q - NWW'(1);
            if (is_last) begin
               full_q <= 1'b0;
            end
         end

         unique case (state_q)
            StIdle: begin
               if (pdw_frame) begin
                  sr_q    <= {sr_q[F-2:0], pdw_data};
                  cnt_q   <= CW'(1);
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (pdw_frame) begin
                  sr_q <= {sr_q[F-2:0], pdw_data};
                  if (cnt_q <= CW'(F)) begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end else begin
                  state_q <= StCheck;
               end
            end
            StCheck: begin
               state_q <= StIdle;
               cnt_q   <= '0;
               if (!len_ok) begin
                  frame_err_q <= 1'b1;
               end else if (!crc_ok) begin
`ifdef PDW_RX_CRC_EN
                  crc_err_q <= 1'b1;
`endif
               end else if (hold_free) begin
                  hold_q <= sr_q[F-1 -: P];
                  full_q <= 1'b1;
                  left_q <= NWW'(NW);
               end else begin
                  overrun_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign word_o       = hold_q[P-1 -: SAMPLE_WIDTH];
   assign word_valid_o = full_q;
   assign word_last_o  = full_q & is_last;
   assign frame_err_o  = frame_err_q;
   assign overrun_o    = overrun_q;
   assign busy_o       = (state_q != StIdle) | full_q;

endmodule

// File: tb/tb_pdw_rx.sv
// Bench for pdw_rx: builds snapshots as payload vectors, splits them into expected words and
// checks the drained stream, error pulses and stall behaviour. Honors PDW_RX_CRC_EN.
module tb_pdw_rx;

   localparam int SW  = 16;
   localparam int NT  = 10;
   localparam int ATW = 32;
   localparam int P   = SW * NT + ATW;
   localparam int NW  = P / SW;
`ifdef PDW_RX_CRC_EN
   localparam int F = P + 16;
`else
   localparam int F = P;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          pdw_data = 1'b0;
   logic          pdw_frame = 1'b0;
   logic          word_ready_i = 1'b0;
   logic [SW-1:0] word_o;
   logic          word_valid_o;
   logic          word_last_o;
   logic          frame_err_o;
   logic          overrun_o;
   logic          busy_o;
`ifdef PDW_RX_CRC_EN
   logic          crc_err_o;
`endif

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int n_ferr = 0;
   int n_ovr = 0;
   int n_crc = 0;
   logic [SW-1:0] obs_w[$];
   logic          obs_l[$];
   int            obs_t[$];

   pdw_rx #(
      .SAMPLE_WIDTH   (SW),
      .NUM_TAPS       (NT),
      .ABS_TIME_WIDTH (ATW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pdw_data     (pdw_data),
      .pdw_frame    (pdw_frame),
      .word_o       (word_o),
      .word_valid_o (word_valid_o),
      .word_ready_i (word_ready_i),
      .word_last_o  (word_last_o),
      .frame_err_o  (frame_err_o),
      .overrun_o    (overrun_o),
`ifdef PDW_RX_CRC_EN
      .crc_err_o    (crc_err_o),
`endif
      .busy_o       (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Transfers and pulses are observed mid-cycle, where inputs and outputs are settled.
   always @(negedge clk) begin
      if (rst_n) begin
         if (word_valid_o && word_ready_i) begin
            obs_w.push_back(word_o);
            obs_l.push_back(word_last_o);
            obs_t.push_back(cyc);
         end
         if (frame_err_o) n_ferr++;
         if (overrun_o) n_ovr++;
`ifdef PDW_RX_CRC_EN
         if (crc_err_o) n_crc++;
`endif
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [15:0] crc_of(input logic [P-1:0] p);
      logic [15:0] c = 16'hFFFF;
      for (int i = P - 1; i >= 0; i--) begin
         c = (c[15] ^ p[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

   function automatic logic [F+1:0] make_frame(input logic [P-1:0] p);
`ifdef PDW_RX_CRC_EN
      return {2'b00, p, crc_of(p)};
`else
      return {2'b00, p};
`endif
   endfunction

   function automatic logic [SW-1:0] word_of(input logic [P-1:0] p, input int k);
      return p[P-1-k*SW -: SW];
   endfunction

   function automatic logic [P-1:0] known_payload();
      logic [P-1:0] p = '0;
      for (int i = 0; i < NT; i++) p[ATW+i*SW +: SW] = SW'(i + 1);
      p[ATW-1:0] = 32'hDEADBEEF;
      return p;
   endfunction

   function automatic logic [P-1:0] rand_payload();
      logic [P-1:0] p = '0;
      for (int i = 0; i < P; i += 32) p[i +: 32] = $urandom();
      return p;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [F+1:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         pdw_frame = 1'b1;
         pdw_data  = v[i];
         tick();
      end
      pdw_frame = 1'b0;
      pdw_data  = 1'b0;
   endtask

   task automatic obs_clear();
      obs_w.delete();
      obs_l.delete();
      obs_t.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst_n = 1'b0;
      #2;
      total++;
      if ({word_valid_o, word_last_o, frame_err_o, overrun_o, busy_o} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 00000",
                  {word_valid_o, word_last_o, frame_err_o, overrun_o, busy_o});
      end
      total++;
      if (word_o !== '0) begin
         bad++;
         $display("FAIL reset_word: got %h want 0000", word_o);
      end
      idle(2);
      rst_n = 1'b1;
      idle(3);
      total++;
      if (busy_o !== 1'b0 || n_ferr !== 0) begin
         bad++;
         $display("FAIL reset_release: busy=%b ferr=%0d want 0 0", busy_o, n_ferr);
      end
   endtask

   task automatic test_known();
      logic [P-1:0] p = known_payload();
      int t_end, f0, o0;
      obs_clear();
      f0 = n_ferr;
      o0 = n_ovr;
      word_ready_i = 1'b1;
      send(make_frame(p), F);
      t_end = cyc;
      idle(40);
      total++;
      if (obs_w.size() !== NW) begin
         bad++;
         $display("FAIL known_count: got %0d want %0d", obs_w.size(), NW);
      end
      for (int k = 0; k < obs_w.size() && k < NW; k++) begin
         total++;
         if (obs_w[k] !== word_of(p, k) || obs_l[k] !== (k == NW - 1)) begin
            bad++;
            $display("FAIL known_word%0d: got %h/%b want %h/%b", k, obs_w[k], obs_l[k],
                     word_of(p, k), (k == NW - 1));
         end
      end
      if (obs_t.size() == NW) begin
         total++;
         if (obs_t[0] !== t_end + 2 || obs_t[NW-1] - obs_t[0] !== NW - 1) begin
            bad++;
            $display("FAIL known_timing: first=%0d span=%0d want %0d %0d", obs_t[0] - t_end,
                     obs_t[NW-1] - obs_t[0], 2, NW - 1);
         end
      end
      total++;
      if (n_ferr - f0 !== 0 || n_ovr - o0 !== 0) begin
         bad++;
         $display("FAIL known_pulses: ferr=%0d ovr=%0d want 0 0", n_ferr - f0, n_ovr - o0);
      end
   endtask

   task automatic test_length();
      int lens[2] = '{F - 1, F + 1};
      logic [F+1:0] v;
      obs_clear();
      word_ready_i = 1'b1;
      foreach (lens[j]) begin
         int f0 = n_ferr;
         for (int i = 0; i < F + 2; i++) v[i] = 1'($urandom_range(0, 1));
         send(v, lens[j]);
         idle(6);
         total++;
         if (n_ferr - f0 !== 1) begin
            bad++;
            $display("FAIL length_%0d_err: got %0d pulses want 1", lens[j], n_ferr - f0);
         end
      end
      total++;
      if (obs_w.size() !== 0) begin
         bad++;
         $display("FAIL length_words: got %0d want 0", obs_w.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [P-1:0] ps[4];
      int o0 = n_ovr;
      int f0 = n_ferr;
      obs_clear();
      word_ready_i = 1'b1;
      foreach (ps[j]) begin
         ps[j] = rand_payload();
         send(make_frame(ps[j]), F);
         idle(2);
      end
      idle(30);
      total++;
      if (obs_w.size() !== 4 * NW || n_ovr - o0 !== 0 || n_ferr - f0 !== 0) begin
         bad++;
         $display("FAIL b2b_count: words=%0d ovr=%0d ferr=%0d want %0d 0 0", obs_w.size(),
                  n_ovr - o0, n_ferr - f0, 4 * NW);
      end
      for (int k = 0; k < obs_w.size() && k < 4 * NW; k++) begin
         total++;
         if (obs_w[k] !== word_of(ps[k/NW], k % NW) || obs_l[k] !== (k % NW == NW - 1)) begin
            bad++;
            $display("FAIL b2b_word%0d: got %h/%b want %h/%b", k, obs_w[k], obs_l[k],
                     word_of(ps[k/NW], k % NW), (k % NW == NW - 1));
         end
      end
   endtask

   task automatic test_overrun();
      logic [P-1:0] a = rand_payload();
      logic [P-1:0] b = rand_payload();
      int o0 = n_ovr;
      obs_clear();
      word_ready_i = 1'b0;
      send(make_frame(a), F);
      idle(4);
      send(make_frame(b), F);
      idle(6);
      total++;
      if (n_ovr - o0 !== 1 || obs_w.size() !== 0 || word_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL overrun_pulse: ovr=%0d words=%0d valid=%b want 1 0 1", n_ovr - o0,
                  obs_w.size(), word_valid_o);
      end
      word_ready_i = 1'b1;
      idle(20);
      total++;
      if (obs_w.size() !== NW) begin
         bad++;
         $display("FAIL overrun_count: got %0d want %0d", obs_w.size(), NW);
      end
      for (int k = 0; k < obs_w.size() && k < NW; k++) begin
         total++;
         if (obs_w[k] !== word_of(a, k)) begin
            bad++;
            $display("FAIL overrun_word%0d: got %h want %h", k, obs_w[k], word_of(a, k));
         end
      end
   endtask

   // Last word of A transfers on the same edge that copies B out of CHECK.
   task automatic test_boundary();
      logic [P-1:0] a = rand_payload();
      logic [P-1:0] b = rand_payload();
      logic [F+1:0] fb = make_frame(b);
      int o0 = n_ovr;
      obs_clear();
      word_ready_i = 1'b0;
      send(make_frame(a), F);
      idle(3);
      for (int i = F - 1; i >= 0; i--) begin
         if (i == 9) word_ready_i = 1'b1;
         pdw_frame = 1'b1;
         pdw_data  = fb[i];
         tick();
      end
      pdw_frame = 1'b0;
      pdw_data  = 1'b0;
      idle(30);
      total++;
      if (n_ovr - o0 !== 0 || obs_w.size() !== 2 * NW) begin
         bad++;
         $display("FAIL boundary_accept: ovr=%0d words=%0d want 0 %0d", n_ovr - o0,
                  obs_w.size(), 2 * NW);
      end
      for (int k = 0; k < obs_w.size() && k < 2 * NW; k++) begin
         total++;
         if (obs_w[k] !== word_of((k < NW) ? a : b, k % NW)) begin
            bad++;
            $display("FAIL boundary_word%0d: got %h want %h", k, obs_w[k],
                     word_of((k < NW) ? a : b, k % NW));
         end
      end
   endtask

   task automatic test_stall();
      logic [P-1:0] p = known_payload();
      logic [SW-1:0] pw = '0;
      logic pl = 1'b0;
      logic stalled = 1'b0;
      obs_clear();
      word_ready_i = 1'b0;
      send(make_frame(p), F);
      for (int i = 0; i < 40; i++) begin
         word_ready_i = (i % 2 == 0);
         @(negedge clk);
         if (stalled) begin
            total++;
            if (word_o !== pw || word_last_o !== pl || word_valid_o !== 1'b1) begin
               bad++;
               $display("FAIL stall_hold: got %h/%b/%b want %h/%b/1", word_o, word_last_o,
                        word_valid_o, pw, pl);
            end
         end
         stalled = word_valid_o && !word_ready_i;
         pw = word_o;
         pl = word_last_o;
         tick();
      end
      word_ready_i = 1'b1;
      idle(5);
      total++;
      if (obs_w.size() !== NW) begin
         bad++;
         $display("FAIL stall_count: got %0d want %0d", obs_w.size(), NW);
      end
      for (int k = 0; k < obs_w.size() && k < NW; k++) begin
         total++;
         if (obs_w[k] !== word_of(p, k) || obs_l[k] !== (k == NW - 1)) begin
            bad++;
            $display("FAIL stall_word%0d: got %h/%b want %h/%b", k, obs_w[k], obs_l[k],
                     word_of(p, k), (k == NW - 1));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [P-1:0] c = rand_payload();
      logic [P-1:0] d = rand_payload();
      logic [F+1:0] fc = make_frame(c);
      int f0, o0;
      obs_clear();
      word_ready_i = 1'b1;
      for (int i = F - 1; i >= F - 100; i--) begin
         pdw_frame = 1'b1;
         pdw_data  = fc[i];
         tick();
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({word_valid_o, word_last_o, frame_err_o, overrun_o, busy_o} !== 5'b0) begin
         bad++;
         $display("FAIL rst_frame: got %b want 00000",
                  {word_valid_o, word_last_o, frame_err_o, overrun_o, busy_o});
      end
      pdw_frame = 1'b0;
      pdw_data  = 1'b0;
      tick();
      rst_n = 1'b1;
      f0 = n_ferr;
      o0 = n_ovr;
      idle(8);
      total++;
      if (n_ferr - f0 !== 0 || n_ovr - o0 !== 0 || obs_w.size() !== 0) begin
         bad++;
         $display("FAIL rst_frame_after: ferr=%0d ovr=%0d words=%0d want 0 0 0", n_ferr - f0,
                  n_ovr - o0, obs_w.size());
      end
      word_ready_i = 1'b0;
      send(fc, F);
      idle(4);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({word_valid_o, word_last_o, busy_o} !== 3'b0 || word_o !== '0) begin
         bad++;
         $display("FAIL rst_drain: flags=%b word=%h want 000 0000",
                  {word_valid_o, word_last_o, busy_o}, word_o);
      end
      tick();
      rst_n = 1'b1;
      word_ready_i = 1'b1;
      idle(3);
      send(make_frame(d), F);
      idle(30);
      total++;
      if (obs_w.size() !== NW) begin
         bad++;
         $display("FAIL rst_next_count: got %0d want %0d", obs_w.size(), NW);
      end
      for (int k = 0; k < obs_w.size() && k < NW; k++) begin
         total++;
         if (obs_w[k] !== word_of(d, k)) begin
            bad++;
            $display("FAIL rst_next_word%0d: got %h want %h", k, obs_w[k], word_of(d, k));
         end
      end
   endtask

`ifdef PDW_RX_CRC_EN
   task automatic test_crc();
      logic [F+1:0] fr = make_frame(known_payload());
      int c0 = n_crc;
      int f0 = n_ferr;
      obs_clear();
      word_ready_i = 1'b1;
      fr[F-1-37] = ~fr[F-1-37];
      send(fr, F);
      idle(20);
      total++;
      if (n_crc - c0 !== 1 || n_ferr - f0 !== 0 || obs_w.size() !== 0) begin
         bad++;
         $display("FAIL crc_flip: crc=%0d ferr=%0d words=%0d want 1 0 0", n_crc - c0,
                  n_ferr - f0, obs_w.size());
      end
      test_known();
   endtask
`endif

   initial begin
      test_reset();
      test_known();
      test_length();
      test_back_to_back();
      test_overrun();
      test_boundary();
      test_stall();
      test_reset_mid();
`ifdef PDW_RX_CRC_EN
      test_crc();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
